// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: MULT/DIV FSM encoding,
// busy-counter width and default unit latencies.
package hazard_unit_pkg;
   localparam int unsigned MD_CNT_W    = 6;
   localparam int unsigned MUL_LAT_DEF = 4;
   localparam int unsigned DIV_LAT_DEF = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdState_t;

   typedef logic [MD_CNT_W-1:0] mdCnt_t;
endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-control bundle between the ID/EX stages and the hazard unit.
interface hazard_unit_if;
   logic [4:0]  ID_Rs;
   logic [4:0]  ID_Rt;
   logic        ID_UsesRt;
   logic        EX_MemRead;
   logic [4:0]  EX_WR_out;
   logic        ID_MDStart;
   logic        ID_MDOp;
   logic        ID_ReadsHiLo;
   logic        EX_BranchTaken;
   logic        PCWrite;
   logic        IF_IDWrite;
   logic        ID_EX_Flush;
   logic        IF_ID_Flush;
   logic        MD_Busy;
   logic [15:0] StallCount;

   modport master (
      output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_WR_out,
             ID_MDStart, ID_MDOp, ID_ReadsHiLo, EX_BranchTaken,
      input  PCWrite, IF_IDWrite, ID_EX_Flush, IF_ID_Flush, MD_Busy, StallCount
   );

   modport slave (
      input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_WR_out,
             ID_MDStart, ID_MDOp, ID_ReadsHiLo, EX_BranchTaken,
      output PCWrite, IF_IDWrite, ID_EX_Flush, IF_ID_Flush, MD_Busy, StallCount
   );
endinterface

// File: rtl/hazard_unit_cmp.sv
// Load-use detector: a load in EX whose destination feeds the ID instruction.
module hazard_cmp (
   input  logic       memRead,
   input  logic [4:0] exWr,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       usesRt,
   output logic       loadUse
);
   // $0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign loadUse = memRead && (exWr != '0) &&
                    ((exWr == rs) || (usesRt && (exWr == rt)));
endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: load-use and MULT/DIV occupancy stalls, branch flushes,
// and a saturating stall-cycle counter.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int unsigned MUL_LAT = MUL_LAT_DEF,
   parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
   input  logic      clk,
   input  logic      rst,
   hazard_unit_if.slave hz
);
   localparam mdCnt_t MUL_RELOAD = mdCnt_t'(MUL_LAT - 1);
   localparam mdCnt_t DIV_RELOAD = mdCnt_t'(DIV_LAT - 1);

   mdState_t    state, stateNext;
   mdCnt_t      cnt, cntNext;
   logic        loadUse;
   logic        mdHazard;
   logic        accept;
   logic        stall;
   logic [15:0] stallCount;

   hazard_cmp uCmp (
      .memRead (hz.EX_MemRead),
      .exWr    (hz.EX_WR_out),
      .rs      (hz.ID_Rs),
      .rt      (hz.ID_Rt),
      .usesRt  (hz.ID_UsesRt),
      .loadUse (loadUse)
   );

   assign mdHazard = (state == BUSY) && (hz.ID_ReadsHiLo || hz.ID_MDStart);
   assign accept   = hz.ID_MDStart && !hz.EX_BranchTaken && !loadUse && !mdHazard;
   // A taken branch squashes the ID instruction, so its hazards never stall.
   assign stall    = !hz.EX_BranchTaken && (loadUse || mdHazard);

   always_comb begin
      hz.PCWrite     = 1'b1;
      hz.IF_IDWrite  = 1'b1;
      hz.ID_EX_Flush = 1'b0;
      hz.IF_ID_Flush = 1'b0;
      if (hz.EX_BranchTaken) begin
         hz.ID_EX_Flush = 1'b1;
         hz.IF_ID_Flush = 1'b1;
      end else if (stall) begin
         hz.PCWrite     = 1'b0;
         hz.IF_IDWrite  = 1'b0;
         hz.ID_EX_Flush = 1'b1;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               stateNext = BUSY;
               cntNext   = hz.ID_MDOp ? DIV_RELOAD : MUL_RELOAD;
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               cntNext = cnt - 1'b1;
            end else if (accept) begin
               cntNext = hz.ID_MDOp ? DIV_RELOAD : MUL_RELOAD;
            end else begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCount <= '0;
      end else if (stall && (stallCount != '1)) begin
         stallCount <= stallCount + 16'd1;
      end
   end

   assign hz.MD_Busy    = (state == BUSY);
   assign hz.StallCount = stallCount;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a reference model feeding a scoreboard queue.
module tb_hazard_unit;
   localparam int unsigned MUL_L = 4;
   localparam int unsigned DIV_L = 32;

   typedef struct {
      logic        pcw;
      logic        ifidw;
      logic        idexf;
      logic        ifidf;
      logic        busy;
      logic [15:0] sc;
   } exp_t;

   logic clk;
   logic rst;
   hazard_unit_if hz ();

   hazard_unit #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   exp_t sb[$];

   bit mBusy;
   int mCnt;
   int mStall;

   function automatic int latOf(logic op);
      return op ? DIV_L : MUL_L;
   endfunction

   function automatic bit mLoadUse();
      return hz.EX_MemRead && (hz.EX_WR_out != 5'd0) &&
             ((hz.EX_WR_out == hz.ID_Rs) || (hz.ID_UsesRt && (hz.EX_WR_out == hz.ID_Rt)));
   endfunction

   function automatic exp_t model();
      exp_t e;
      bit lu, mdh;
      lu  = mLoadUse();
      mdh = mBusy && (hz.ID_ReadsHiLo || hz.ID_MDStart);
      if (hz.EX_BranchTaken) begin
         e.pcw = 1; e.ifidw = 1; e.idexf = 1; e.ifidf = 1;
      end else if (lu || mdh) begin
         e.pcw = 0; e.ifidw = 0; e.idexf = 1; e.ifidf = 0;
      end else begin
         e.pcw = 1; e.ifidw = 1; e.idexf = 0; e.ifidf = 0;
      end
      e.busy = mBusy;
      e.sc   = 16'(mStall);
      return e;
   endfunction

   task automatic mReset();
      mBusy = 0; mCnt = 0; mStall = 0;
   endtask

   // Called just after a rising edge, inputs still as they were at the edge.
   task automatic advance();
      exp_t e;
      bit lu, mdh, acc;
      if (!rst) begin
         mReset();
         return;
      end
      e   = model();
      lu  = mLoadUse();
      mdh = mBusy && (hz.ID_ReadsHiLo || hz.ID_MDStart);
      acc = hz.ID_MDStart && !hz.EX_BranchTaken && !lu && !mdh;
      if (!e.pcw && mStall < 65535) mStall++;
      if (!mBusy) begin
         if (acc) begin mBusy = 1; mCnt = latOf(hz.ID_MDOp) - 1; end
      end else if (mCnt > 0) begin
         mCnt--;
      end else if (acc) begin
         mCnt = latOf(hz.ID_MDOp) - 1;
      end else begin
         mBusy = 0;
      end
   endtask

   task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(string tag);
      exp_t e;
      sb.push_back(model());
      @(negedge clk);
      e = sb.pop_front();
      check({tag, ".PCWrite"},     16'(hz.PCWrite),     16'(e.pcw));
      check({tag, ".IF_IDWrite"},  16'(hz.IF_IDWrite),  16'(e.ifidw));
      check({tag, ".ID_EX_Flush"}, 16'(hz.ID_EX_Flush), 16'(e.idexf));
      check({tag, ".IF_ID_Flush"}, 16'(hz.IF_ID_Flush), 16'(e.ifidf));
      check({tag, ".MD_Busy"},     16'(hz.MD_Busy),     16'(e.busy));
      check({tag, ".StallCount"},  hz.StallCount,       e.sc);
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic quiet(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         advance();
      end
      #1;
   endtask

   task automatic clearIn();
      hz.ID_Rs = '0; hz.ID_Rt = '0; hz.ID_UsesRt = 0; hz.EX_MemRead = 0;
      hz.EX_WR_out = '0; hz.ID_MDStart = 0; hz.ID_MDOp = 0;
      hz.ID_ReadsHiLo = 0; hz.EX_BranchTaken = 0;
   endtask

   initial begin
      clearIn();
      rst = 0;
      mReset();
      cyc("reset_idle");
      hz.EX_MemRead = 1; hz.EX_WR_out = 5'd3; hz.ID_Rs = 5'd3;
      cyc("reset_comb");
      clearIn();
      rst = 1;
      cyc("release_idle");

      // load-use through Rs, then through Rt
      hz.EX_MemRead = 1; hz.EX_WR_out = 5'd8; hz.ID_Rs = 5'd8;
      cyc("lu_rs");
      clearIn();
      cyc("lu_rs_after");
      hz.EX_MemRead = 1; hz.EX_WR_out = 5'd9; hz.ID_Rs = 5'd1; hz.ID_Rt = 5'd9; hz.ID_UsesRt = 1;
      cyc("lu_rt");
      hz.ID_UsesRt = 0;
      cyc("lu_rt_unused");
      hz.EX_WR_out = 5'd0; hz.ID_Rs = 5'd0; hz.ID_Rt = 5'd0; hz.ID_UsesRt = 1;
      cyc("lu_r0");
      hz.EX_MemRead = 0; hz.EX_WR_out = 5'd8; hz.ID_Rs = 5'd8;
      cyc("no_load");
      clearIn();

      // branch beats load-use and squashes a MULT
      hz.EX_BranchTaken = 1; hz.EX_MemRead = 1; hz.EX_WR_out = 5'd4; hz.ID_Rs = 5'd4; hz.ID_MDStart = 1;
      cyc("branch_prio");
      clearIn();
      cyc("branch_no_accept");

      // DIV then MFLO
      hz.ID_MDStart = 1; hz.ID_MDOp = 1;
      cyc("div_accept");
      clearIn();
      hz.ID_ReadsHiLo = 1;
      for (int i = 1; i <= 33; i++) cyc($sformatf("div_mflo_%0d", i));
      clearIn();
      cyc("div_done");

      // MULT aborted by reset
      hz.ID_MDStart = 1;
      cyc("mul_accept");
      clearIn();
      cyc("mul_busy1");
      rst = 0;
      mReset();
      #1;
      check("async.MD_Busy",    16'(hz.MD_Busy), 16'd0);
      check("async.StallCount", hz.StallCount,   16'd0);
      cyc("in_reset");
      rst = 1;
      cyc("after_release");

      // full MULT occupancy
      hz.ID_MDStart = 1;
      cyc("mul2_accept");
      clearIn();
      for (int i = 1; i <= 5; i++) cyc($sformatf("mul2_%0d", i));

      // stall-counter saturation
      hz.EX_MemRead = 1; hz.EX_WR_out = 5'd7; hz.ID_Rs = 5'd7;
      quiet(70000);
      cyc("sat");
      check("sat.hold", hz.StallCount, 16'hFFFF);
      clearIn();
      cyc("sat_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
